// File: rtl/fsm_burst.sv
// fsm_burst: edge-triggered counting burst generator, IDLE -> RUN -> HOLD -> DONE -> IDLE.
// Optional macro FSM_BURST_ABORT_EN: dropping en during RUN or HOLD aborts the burst back to IDLE.
module fsm_burst #(
    parameter int DW       = 4,
    parameter int CNT_MAX  = 10,
    parameter int HOLD_CYC = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          dir,
    output logic [DW-1:0] dout,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [DW-1:0] TOP_VAL   = DW'(CNT_MAX - 1);
    localparam logic [7:0]    HOLD_LAST = 8'(HOLD_CYC - 1);

    generate
        if (DW < 1 || DW > 30) begin : g_bad_dw
            $error("fsm_burst: DW=%0d out of range 1..30", DW);
        end
        if (CNT_MAX < 1 || CNT_MAX > (2 ** DW)) begin : g_bad_cnt
            $error("fsm_burst: CNT_MAX=%0d out of range 1..2**DW", CNT_MAX);
        end
        if (HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_hold
            $error("fsm_burst: HOLD_CYC=%0d out of range 1..255", HOLD_CYC);
        end
    endgenerate

    state_t        state_q;
    state_t        state_n;
    logic [DW-1:0] dout_q;
    logic [DW-1:0] dout_n;
    logic          dir_q;
    logic          dir_n;
    logic [7:0]    hold_cnt;
    logic [7:0]    hold_n;
    logic          en_d;
    logic          done_q;
    logic          start;
    logic [DW-1:0] last_val;

    assign start    = en & ~en_d & (state_q == IDLE);
    assign last_val = dir_q ? '0 : TOP_VAL;

    always_comb begin
        state_n = state_q;
        dout_n  = dout_q;
        dir_n   = dir_q;
        hold_n  = hold_cnt;
        case (state_q)
            IDLE: begin
                dout_n = '0;
                hold_n = '0;
                if (start) begin
                    state_n = RUN;
                    dir_n   = dir;
                    dout_n  = dir ? TOP_VAL : '0;
                end
            end
            RUN: begin
                if (dout_q != last_val) begin
                    dout_n = dir_q ? (dout_q - DW'(1)) : (dout_q + DW'(1));
                end else begin
                    state_n = HOLD;
                    hold_n  = '0;
                end
            end
            HOLD: begin
                hold_n = hold_cnt + 8'd1;
                if (hold_cnt == HOLD_LAST) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
                dout_n  = '0;
                hold_n  = '0;
            end
            default: begin
                state_n = IDLE;
                dout_n  = '0;
                hold_n  = '0;
            end
        endcase
`ifdef FSM_BURST_ABORT_EN
        // Abort wins over normal sequencing; DONE is never reached on this path.
        if ((state_q == RUN || state_q == HOLD) && !en) begin
            state_n = IDLE;
            dout_n  = '0;
            hold_n  = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dout_q   <= '0;
            dir_q    <= 1'b0;
            hold_cnt <= '0;
            en_d     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            dout_q   <= dout_n;
            dir_q    <= dir_n;
            hold_cnt <= hold_n;
            en_d     <= en;
            done_q   <= (state_n == DONE);
        end
    end

    // done comes from its own flop so it is glitch-free and aligned with state == DONE.
    assign dout  = dout_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_fsm_burst.sv
// Self-checking bench for fsm_burst: directed scenarios plus random en/dir, against a queue-based burst model.
module tb_fsm_burst;

    localparam int DW       = 4;
    localparam int CNT_MAX  = 10;
    localparam int HOLD_CYC = 3;

`ifdef FSM_BURST_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          dir;
    logic [DW-1:0] dout;
    logic          busy;
    logic          done;
    logic [1:0]    state;

    fsm_burst #(.DW(DW), .CNT_MAX(CNT_MAX), .HOLD_CYC(HOLD_CYC)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .dir  (dir),
        .dout (dout),
        .busy (busy),
        .done (done),
        .state(state)
    );

    always #5 clk = ~clk;

    // Model: a started burst is expanded into the full list of (state, dout) it must show, one per cycle.
    typedef struct packed {
        logic [1:0]    st;
        logic [DW-1:0] d;
    } ent_t;

    ent_t exp_q[$];
    logic en_prev;
    int   errors = 0;
    int   checks = 0;
    int   done_seen, model_done, busy_seen, model_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        en_prev = 1'b0;
    endtask

    task automatic model_edge();
        logic [DW-1:0] dv;
        logic [DW-1:0] last;
        if (rst) begin
            model_reset();
            return;
        end
        if (exp_q.size() != 0) begin
            if (ABORT && !en && (exp_q[0].st == 2'd1 || exp_q[0].st == 2'd2))
                exp_q.delete();
            else
                void'(exp_q.pop_front());
        end else if (en && !en_prev) begin
            for (int i = 0; i < CNT_MAX; i++) begin
                dv = dir ? DW'(CNT_MAX - 1 - i) : DW'(i);
                exp_q.push_back({2'd1, dv});
            end
            last = dir ? '0 : DW'(CNT_MAX - 1);
            for (int i = 0; i < HOLD_CYC; i++) exp_q.push_back({2'd2, last});
            exp_q.push_back({2'd3, last});
        end
        en_prev = en;
    endtask

    task automatic check_all(input string tag);
        logic [1:0]    es;
        logic [DW-1:0] ed;
        es = (exp_q.size() != 0) ? exp_q[0].st : 2'd0;
        ed = (exp_q.size() != 0) ? exp_q[0].d  : '0;
        chk($sformatf("%s.state", tag), 32'(state), 32'(es));
        chk($sformatf("%s.dout",  tag), 32'(dout),  32'(ed));
        chk($sformatf("%s.busy",  tag), 32'(busy),  32'(es != 2'd0));
        chk($sformatf("%s.done",  tag), 32'(done),  32'(es == 2'd3));
        if (done === 1'b1) done_seen++;
        if (busy === 1'b1) busy_seen++;
        if (es == 2'd3)  model_done++;
        if (es != 2'd0)  model_busy++;
    endtask

    task automatic step(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all(tag);
        end
    endtask

    task automatic clr_counts();
        done_seen = 0; busy_seen = 0; model_done = 0; model_busy = 0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0;
        model_reset();
        clr_counts();
        step("reset", 2);

        // Up burst: en high 3 cycles.
        rst = 1'b0;
        step("up_idle", 1);
        clr_counts();
        en = 1'b1; step("up", 3);
        en = 1'b0; step("up", 17);
        chk("up.busy_len", 32'(busy_seen), 32'(ABORT ? 3 : CNT_MAX + HOLD_CYC + 1));
        chk("up.done_cnt", 32'(done_seen), 32'(ABORT ? 0 : 1));

        // Down burst with a dir toggle mid-burst.
        clr_counts();
        dir = 1'b1; en = 1'b1; step("down", 6);
        dir = 1'b0; step("down", 14);
        en = 1'b0; step("down", 3);
        chk("down.busy_len", 32'(busy_seen), 32'(CNT_MAX + HOLD_CYC + 1));
        chk("down.done_cnt", 32'(done_seen), 32'd1);

        // Retrigger: en held high 30 cycles gives one burst only.
        clr_counts();
        en = 1'b1; step("hold_hi", 30);
        en = 1'b0; step("hold_hi", 2);
        chk("hold_hi.done_cnt", 32'(done_seen), 32'd1);
        chk("hold_hi.busy_len", 32'(busy_seen), 32'(CNT_MAX + HOLD_CYC + 1));

        // en pulse during HOLD must not queue a second burst.
        clr_counts();
        en = 1'b1; step("retrig", 1);
        en = 1'b0; step("retrig", CNT_MAX);
        en = 1'b1; step("retrig", 1);
        en = 1'b0; step("retrig", 8);
        chk("retrig.done_cnt", 32'(done_seen), 32'(model_done));
        chk("retrig.busy_len", 32'(busy_seen), 32'(model_busy));

        // Asynchronous reset mid-burst at dout=5.
        clr_counts();
        dir = 1'b0; en = 1'b1; step("rst_mid", 6);
        chk("rst_mid.pre_dout", 32'(dout), 32'd5);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rst_async");
        step("rst_hold", 2);
        rst = 1'b0; en = 1'b0; step("rst_rel", 1);
        en = 1'b1; step("rst_restart", 16);
        chk("rst_mid.done_cnt", 32'(done_seen), 32'd1);

        // en already high at the first edge after reset release.
        clr_counts();
        rst = 1'b1; step("rel_en", 1);
        rst = 1'b0; step("rel_en", 16);
        en = 1'b0; step("rel_en", 1);
        chk("rel_en.done_cnt", 32'(done_seen), 32'd1);

        // Abort stimulus: en high 4 cycles then low.
        clr_counts();
        en = 1'b1; step("abort", 4);
        en = 1'b0; step("abort", 16);
        chk("abort.busy_len", 32'(busy_seen), 32'(ABORT ? 4 : CNT_MAX + HOLD_CYC + 1));
        chk("abort.done_cnt", 32'(done_seen), 32'(ABORT ? 0 : 1));

        // Random en/dir traffic.
        clr_counts();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) en = ~en;
            dir = 1'($urandom_range(0, 1));
            step("rand", 1);
        end
        chk("rand.done_cnt", 32'(done_seen), 32'(model_done));
        chk("rand.busy_len", 32'(busy_seen), 32'(model_busy));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
